// File: rtl/mux_uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// mux_uart_rx_pkg
// Shared definitions for the MUX UART receive path:
//   - register offsets relative to BASE_ADDR (REG_STAT, REG_DATA)
//   - status byte bit positions (ST_RXRDY, ST_TXRDY, ST_FERR, ST_OVR)
//   - receive FSM state encodings (S_IDLE, S_START, S_DATA, S_STOP)
//   - status_byte(): assembles the status register image
// ---------------------------------------------------------------------------
package mux_uart_rx_pkg;

    localparam logic [18:0] REG_STAT = 19'd0;
    localparam logic [18:0] REG_DATA = 19'd1;

    localparam int ST_RXRDY = 0;
    localparam int ST_TXRDY = 1;
    localparam int ST_FERR  = 2;
    localparam int ST_OVR   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_e;

    // TX-ready is always reported as 1 so console writes never stall.
    function automatic logic [7:0] status_byte(input logic rxrdy,
                                               input logic ferr,
                                               input logic ovr);
        logic [7:0] s;
        s           = 8'h00;
        s[ST_RXRDY] = rxrdy;
        s[ST_TXRDY] = 1'b1;
        s[ST_FERR]  = ferr;
        s[ST_OVR]   = ovr;
        return s;
    endfunction

endpackage

// File: rtl/mux_uart_fifo.sv
// ---------------------------------------------------------------------------
// mux_uart_fifo
// Generic synchronous first-word-fall-through FIFO (dout shows the head entry
// whenever empty=0). Shared by the RX path and, later, the TX path.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous active-high reset (empties the FIFO)
//   push   in   write din; accepted when not full, or when full with a pop
//   pop    in   remove head entry; ignored when empty
//   din    in   WIDTH write data
//   dout   out  WIDTH head entry
//   empty  out  no entries stored
//   full   out  DEPTH entries stored
// DEPTH must be a power of 2 (>= 2) so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module mux_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    logic do_push;
    logic do_pop;

    // A push into a full FIFO only lands if the head leaves in the same cycle;
    // a pop of an empty FIFO is ignored, so push+pop while empty is a plain push.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/mux_uart_rx.sv
// ---------------------------------------------------------------------------
// mux_uart_rx
// Receive half of CPU6 MUX UART port 0. Deserialises 8N1 frames from rx into
// a small FIFO and exposes it on the CPU6 bus:
//   BASE_ADDR+0  status  {4'b0, ovr, ferr, txrdy=1, rxrdy}; write bit2 clears
//                        ferr, bit3 clears ovr
//   BASE_ADDR+1  data    read pops the FIFO head (8'h00 when empty); writes
//                        are ignored here
// Optional feature macro: MUX_UART_IRQ_EN -- when defined, int_reqn is driven
// low (irq_number = IRQ_NUM) while the FIFO holds data; otherwise int_reqn is
// tied high and irq_number tied 0.
// Ports:
//   clock       in   system clock
//   reset       in   synchronous active-high reset
//   address     in   19-bit CPU6 bus address
//   read_en     in   one-clock read strobe
//   write_en    in   write strobe
//   data_in     in   8-bit write data
//   data_out    out  8-bit read data, 8'h00 when not addressed
//   rx          in   asynchronous serial input, idles high
//   int_reqn    out  active-low interrupt request
//   irq_number  out  interrupt level while requesting, else 0
// ---------------------------------------------------------------------------
module mux_uart_rx
    import mux_uart_rx_pkg::*;
#(
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [18:0] BASE_ADDR  = 19'h3f200,
    parameter logic [3:0]  IRQ_NUM    = 4'd6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [18:0] address,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    input  logic        rx,
    output logic        int_reqn,
    output logic [3:0]  irq_number
);

    localparam int               CNT_W     = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [18:0]      STAT_ADDR = BASE_ADDR + REG_STAT;
    localparam logic [18:0]      DATA_ADDR = BASE_ADDR + REG_DATA;

    // ---------------- rx synchroniser ----------------
    logic rx_meta_q;
    logic rx_s_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // ---------------- receive FSM ----------------
    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             push_q;      // one-cycle pulse: shift_q holds a good byte
    logic             ferr_set_q;  // one-cycle pulse: stop bit was 0

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            push_q     <= 1'b0;
            ferr_set_q <= 1'b0;
        end else begin
            push_q     <= 1'b0;
            ferr_set_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                    end
                end
                S_START: begin
                    // Re-check the line half a bit in; a high level here means
                    // the falling edge was a glitch.
                    if (cnt_q == CNT_MID) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        state_q <= rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s_q, shift_q[7:1]};  // LSB arrives first
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q      <= '0;
                        push_q     <= rx_s_q;
                        ferr_set_q <= ~rx_s_q;
                        state_q    <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ---------------- receive FIFO ----------------
    logic       fifo_pop;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_full;

    mux_uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_q),
        .pop   (fifo_pop),
        .din   (shift_q),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // ---------------- bus decode and flags ----------------
    logic stat_sel;
    logic data_sel;
    logic stat_wr;
    logic ovr_set;
    logic ferr_q, ferr_d;
    logic ovr_q, ovr_d;

    assign stat_sel = (address == STAT_ADDR);
    assign data_sel = (address == DATA_ADDR);
    assign stat_wr  = write_en & stat_sel;
    assign fifo_pop = read_en & data_sel & ~fifo_empty;

    // Overflow only when the byte is really lost: a simultaneous pop frees a slot.
    assign ovr_set = push_q & fifo_full & ~fifo_pop;

    // Set has priority over a software clear in the same cycle.
    assign ferr_d = ferr_set_q | (ferr_q & ~(stat_wr & data_in[ST_FERR]));
    assign ovr_d  = ovr_set    | (ovr_q  & ~(stat_wr & data_in[ST_OVR]));

    always_ff @(posedge clock) begin
        if (reset) begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            ferr_q <= ferr_d;
            ovr_q  <= ovr_d;
        end
    end

    always_comb begin
        data_out = 8'h00;
        if (stat_sel) begin
            data_out = status_byte(~fifo_empty, ferr_q, ovr_q);
        end else if (data_sel && !fifo_empty) begin
            data_out = fifo_dout;
        end
    end

    // Only the two clear bits of a status write are meaningful.
    logic unused_data_in;
    assign unused_data_in = ^{data_in[7:4], data_in[1:0]};

    // ---------------- interrupt ----------------
`ifdef MUX_UART_IRQ_EN
    assign int_reqn   = fifo_empty;
    assign irq_number = fifo_empty ? 4'd0 : IRQ_NUM;
`else
    assign int_reqn   = 1'b1;
    assign irq_number = 4'd0;
`endif

endmodule

// File: tb/tb_mux_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_mux_uart_rx
// Drives serial frames and CPU bus cycles into mux_uart_rx. Each bus read
// pushes its expected response (from a queue-based model of the receiver)
// into a scoreboard; a separate monitor pops and compares whenever a read
// strobe is presented. Directed scenarios are followed by a random mix.
// ---------------------------------------------------------------------------
module tb_mux_uart_rx;

    localparam int          CLK_DIV = 16;
    localparam int          DEPTH   = 4;
    localparam logic [18:0] BASE    = 19'h3f200;
    localparam logic [18:0] DATA    = 19'h3f201;
    localparam logic [3:0]  IRQ     = 4'd6;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [18:0] address = '0;
    logic        read_en = 1'b0;
    logic        write_en = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        rx = 1'b1;
    logic        int_reqn;
    logic [3:0]  irq_number;

    always #5 clock = ~clock;

    mux_uart_rx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH),
        .BASE_ADDR  (BASE),
        .IRQ_NUM    (IRQ)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .address    (address),
        .read_en    (read_en),
        .write_en   (write_en),
        .data_in    (data_in),
        .data_out   (data_out),
        .rx         (rx),
        .int_reqn   (int_reqn),
        .irq_number (irq_number)
    );

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       irqn;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_q[$];
    logic       m_ferr = 1'b0;
    logic       m_ovr  = 1'b0;
    int         checks   = 0;
    int         failures = 0;
    exp_t       mon_e;

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_status();
        return {4'b0000, m_ovr, m_ferr, 1'b1, (model_q.size() != 0)};
    endfunction

    function automatic logic model_irqn();
`ifdef MUX_UART_IRQ_EN
        return (model_q.size() == 0);
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model_frame(input logic [7:0] b, input logic stop_ok);
        if (!stop_ok)                  m_ferr = 1'b1;
        else if (model_q.size() < DEPTH) model_q.push_back(b);
        else                           m_ovr = 1'b1;
    endfunction

    // ---------------- drivers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bus_read(input logic [18:0] a, input string name);
        exp_t e;
        e.name = name;
        e.irqn = model_irqn();
        if (a == BASE)      e.data = model_status();
        else if (a == DATA) e.data = (model_q.size() != 0) ? model_q.pop_front() : 8'h00;
        else                e.data = 8'h00;
        exp_q.push_back(e);
        address = a;
        read_en = 1'b1;
        step(1);
        read_en = 1'b0;
        address = '0;
    endtask

    task automatic bus_write(input logic [18:0] a, input logic [7:0] d);
        address  = a;
        data_in  = d;
        write_en = 1'b1;
        step(1);
        write_en = 1'b0;
        address  = '0;
        data_in  = 8'h00;
        if (a == BASE) begin
            if (d[2]) m_ferr = 1'b0;
            if (d[3]) m_ovr  = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        step(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(CLK_DIV);
        end
        rx = stop_ok;
        step(CLK_DIV);
        rx = 1'b1;
        step(4);
        model_frame(b, stop_ok);
    endtask

    task automatic glitch(input int len);
        rx = 1'b0;
        step(len);
        rx = 1'b1;
        step(CLK_DIV + 4);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (read_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_read: got data=%02h with no expectation queued", data_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (data_out !== mon_e.data) begin
                        failures++;
                        $display("FAIL %s: data_out=%02h expected %02h", mon_e.name, data_out, mon_e.data);
                    end else begin
                        $display("read %-12s data=%02h int_reqn=%0b irq=%0d", mon_e.name, data_out, int_reqn, irq_number);
                    end
                    checks++;
                    if (int_reqn !== mon_e.irqn ||
                        irq_number !== (mon_e.irqn ? 4'd0 : IRQ)) begin
                        failures++;
                        $display("FAIL %s_irq: int_reqn=%0b irq_number=%0d expected int_reqn=%0b irq_number=%0d",
                                 mon_e.name, int_reqn, irq_number, mon_e.irqn, mon_e.irqn ? 4'd0 : IRQ);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rb;
        int         op;

        step(3);
        reset = 1'b0;
        step(2);

        // Reset state
        bus_read(BASE, "rst_stat");
        bus_read(DATA, "rst_data");
        bus_read(19'h00100, "unselected");

        // Single frame
        send_frame(8'h41, 1'b1);
        bus_read(BASE, "t1_stat");
        bus_read(DATA, "t1_data");
        bus_read(BASE, "t1_stat2");

        // Short glitch must be rejected, receiver still usable afterwards
        glitch(3);
        bus_read(BASE, "t2_stat");
        send_frame(8'h3C, 1'b1);
        bus_read(DATA, "t2_data");

        // Framing error and clear
        send_frame(8'h55, 1'b0);
        bus_read(BASE, "t3_stat");
        bus_read(DATA, "t3_data");
        bus_write(BASE, 8'h04);
        bus_read(BASE, "t3_clr");

        // Overflow with a full FIFO
        for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b1);
        bus_read(BASE, "t4_stat");
        for (int i = 0; i < 5; i++) bus_read(DATA, "t4_data");
        bus_read(BASE, "t4_stat2");
        bus_write(DATA, 8'hFF);
        bus_write(BASE, 8'h08);
        bus_read(BASE, "t4_clr");

        // Reset in the middle of DATA
        send_frame(8'h99, 1'b1);
        send_frame(8'h66, 1'b0);
        rx = 1'b0;
        step(CLK_DIV);
        rx = 1'b0;
        step(3 * CLK_DIV);
        rx = 1'b1;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        model_q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        step(2);
        bus_read(BASE, "t5_stat");
        step(12 * CLK_DIV);
        send_frame(8'hA5, 1'b1);
        bus_read(DATA, "t5_data");

        // Interrupt behaviour
        send_frame(8'h7E, 1'b1);
        bus_read(BASE, "t6_stat");
        bus_read(DATA, "t6_data");
        bus_read(BASE, "t6_after");

        // Random mix
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 8));
            rb = 8'($urandom);
            case (op)
                0, 1, 2, 3: send_frame(rb, ($urandom_range(0, 5) != 0));
                4:          glitch(int'($urandom_range(1, 5)));
                5:          bus_read(BASE, "rnd_stat");
                6, 7:       bus_read(DATA, "rnd_data");
                default:    bus_write(($urandom_range(0, 1) != 0) ? BASE : DATA, rb);
            endcase
        end
        while (model_q.size() != 0) bus_read(DATA, "drain_data");
        bus_read(BASE, "drain_stat");

        step(2);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
